// File: rtl/branch_predict_unit.sv
// Direction predictor: a table of 2-bit saturating counters looked up at fetch and
// trained by branches resolved in execute. Optional statistics under BPU_STATS_EN.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic            pred_out_valid,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [6:0]      res_opcode,
  input  logic [2:0]      res_funct3,
  input  logic [XLEN-1:0] res_rs1,
  input  logic [XLEN-1:0] res_rs2,
  input  logic            res_pred_taken,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            res_illegal,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);
  localparam int         IDX       = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [BHT_ENTRIES-1:0][1:0] bht_q;
  logic [IDX-1:0] p_idx, r_idx;
  logic           is_br, illegal, legal, cond;
  logic [1:0]     ctr_cur, ctr_nxt, p_ctr;

  logic pred_taken_q, pred_taken_d, pred_vld_q;
  logic res_taken_q, res_taken_d, res_misp_q, res_misp_d, res_ill_q, res_ill_d;

  assign p_idx = pred_pc[IDX+1:2];
  assign r_idx = res_pc[IDX+1:2];

  // Upper and byte-offset PC bits never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0],
                            res_pc[XLEN-1:IDX+2], res_pc[1:0]};

  assign is_br   = res_valid && (res_opcode == OP_BRANCH);
  assign illegal = is_br && (res_funct3 == 3'b010 || res_funct3 == 3'b011);
  assign legal   = is_br && !illegal;

  always_comb begin
    cond = 1'b0;
    case (res_funct3)
      3'b000:  cond = (res_rs1 == res_rs2);
      3'b001:  cond = (res_rs1 != res_rs2);
      3'b100:  cond = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101:  cond = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110:  cond = (res_rs1 <  res_rs2);
      3'b111:  cond = (res_rs1 >= res_rs2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    ctr_cur = bht_q[r_idx];
    ctr_nxt = ctr_cur;
    if (cond && ctr_cur != 2'b11)       ctr_nxt = ctr_cur + 2'd1;
    else if (!cond && ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
  end

  // Same-index lookup sees the counter as it will be after this edge's update.
  always_comb begin
    p_ctr = bht_q[p_idx];
    if (legal && (p_idx == r_idx)) p_ctr = ctr_nxt;
  end

  assign pred_taken_d = pred_valid & p_ctr[1];
  assign res_taken_d  = legal & cond;
  assign res_misp_d   = legal & (cond != res_pred_taken);
  assign res_ill_d    = illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (legal) begin
      bht_q[r_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_taken_q <= 1'b0;
      pred_vld_q   <= 1'b0;
      res_taken_q  <= 1'b0;
      res_misp_q   <= 1'b0;
      res_ill_q    <= 1'b0;
    end else begin
      pred_taken_q <= pred_taken_d;
      pred_vld_q   <= pred_valid;
      res_taken_q  <= res_taken_d;
      res_misp_q   <= res_misp_d;
      res_ill_q    <= res_ill_d;
    end
  end

  assign pred_taken     = pred_taken_q;
  assign pred_out_valid = pred_vld_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_misp_q;
  assign res_illegal    = res_ill_q;

`ifdef BPU_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (legal && stat_br_q != '1)              stat_br_q <= stat_br_q + 32'd1;
      if (legal && res_misp_d && stat_mp_q != '1) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Random and directed stimulus against a table-of-integers reference model of the
// predictor; statistics are expected only when BPU_STATS_EN is defined.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken, pred_out_valid;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [6:0]  res_opcode;
  logic [2:0]  res_funct3;
  logic [31:0] res_rs1, res_rs2;
  logic        res_pred_taken;
  logic        res_taken, res_mispredict, res_illegal;
  logic [31:0] stat_branches, stat_mispredicts;

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_out_valid(pred_out_valid),
    .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode),
    .res_funct3(res_funct3), .res_rs1(res_rs1), .res_rs2(res_rs2),
    .res_pred_taken(res_pred_taken), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_illegal(res_illegal),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  int     bht [64];
  longint sb, sm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all registered outputs.
  task automatic step(input bit r, input bit pv, input logic [31:0] ppc,
                      input bit rv, input logic [31:0] rpc, input logic [6:0] op,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input bit rpt);
    bit br, ill, leg, tk, mp, e_pt, e_pv;
    int ri, pi, sa, sbb;
    rst = r; pred_valid = pv; pred_pc = ppc; res_valid = rv; res_pc = rpc;
    res_opcode = op; res_funct3 = f3; res_rs1 = a; res_rs2 = b; res_pred_taken = rpt;
    br = 0; ill = 0; leg = 0; tk = 0; mp = 0; e_pt = 0; e_pv = 0;
    if (r) begin
      foreach (bht[i]) bht[i] = 1;
      sb = 0; sm = 0;
    end else begin
      sa = a; sbb = b;
      br  = rv && (op == 7'h63);
      ill = br && (f3 == 3'd2 || f3 == 3'd3);
      leg = br && !ill;
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = (sa < sbb);
        3'd5: tk = (sa >= sbb);
        3'd6: tk = (a < b);
        3'd7: tk = (a >= b);
        default: tk = 0;
      endcase
      tk = tk && leg;
      mp = leg && (tk != rpt);
      if (leg) begin
        ri = int'(rpc[7:2]);
        bht[ri] = tk ? ((bht[ri] < 3) ? bht[ri] + 1 : 3) : ((bht[ri] > 0) ? bht[ri] - 1 : 0);
`ifdef BPU_STATS_EN
        if (sb < 64'hFFFF_FFFF) sb++;
        if (mp && sm < 64'hFFFF_FFFF) sm++;
`endif
      end
      pi   = int'(ppc[7:2]);
      e_pv = pv;
      e_pt = pv && (bht[pi] >= 2);
    end
    @(posedge clk); #1;
    chk("pred_out_valid", {31'b0, pred_out_valid}, {31'b0, e_pv});
    chk("pred_taken",     {31'b0, pred_taken},     {31'b0, e_pt});
    chk("res_taken",      {31'b0, res_taken},      {31'b0, tk});
    chk("res_mispredict", {31'b0, res_mispredict}, {31'b0, mp});
    chk("res_illegal",    {31'b0, res_illegal},    {31'b0, ill});
    chk("stat_branches",    stat_branches,    sb[31:0]);
    chk("stat_mispredicts", stat_mispredicts, sm[31:0]);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] ops [4] = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000};

  initial begin
    sb = 0; sm = 0;
    // Requests during reset are discarded.
    step(1, 1, 32'h100, 1, 32'h100, 7'h63, 3'd0, 5, 5, 0);
    chk("rst_pred_vld", {31'b0, pred_out_valid}, 32'd0);
    chk("rst_res_taken", {31'b0, res_taken}, 32'd0);

    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("lookup_0x100_vld", {31'b0, pred_out_valid}, 32'd1);
    chk("lookup_0x100_nt", {31'b0, pred_taken}, 32'd0);

    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 32'h100, 7'h63, 3'd0, 5, 5, 0);
      chk("beq_taken", {31'b0, res_taken}, 32'd1);
      chk("beq_misp", {31'b0, res_mispredict}, 32'd1);
    end
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("lookup_0x100_t", {31'b0, pred_taken}, 32'd1);

    step(0, 0, 0, 1, 32'h200, 7'h63, 3'd4, 32'hFFFF_FFFF, 1, 1);
    chk("blt_signed", {31'b0, res_taken}, 32'd1);
    step(0, 0, 0, 1, 32'h200, 7'h63, 3'd6, 32'hFFFF_FFFF, 1, 1);
    chk("bltu", {31'b0, res_taken}, 32'd0);
    step(0, 0, 0, 1, 32'h200, 7'h63, 3'd7, 32'hFFFF_FFFF, 1, 1);
    chk("bgeu", {31'b0, res_taken}, 32'd1);

    step(0, 0, 0, 1, 32'h100, 7'h63, 3'd2, 5, 5, 0);
    chk("illegal_flag", {31'b0, res_illegal}, 32'd1);
    chk("illegal_taken", {31'b0, res_taken}, 32'd0);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("illegal_no_upd", {31'b0, pred_taken}, 32'd1);

    // Bypass at 0x40 (counter 01 -> 10) and independent lookup at 0x44.
    step(0, 1, 32'h40, 1, 32'h40, 7'h63, 3'd0, 7, 7, 0);
    chk("bypass_0x40", {31'b0, pred_taken}, 32'd1);
    step(0, 1, 32'h44, 1, 32'h40, 7'h63, 3'd0, 7, 7, 1);
    chk("indep_0x44", {31'b0, pred_taken}, 32'd0);

    // Ten branches, three mispredicts, then reset mid-stream.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      step(0, 0, 0, 1, 32'h300 + 32'(k * 4), 7'h63, 3'd0, 1, 1, (k >= 3));
`ifdef BPU_STATS_EN
    chk("stats_br_10", stat_branches, 32'd10);
    chk("stats_mp_3", stat_mispredicts, 32'd3);
`endif
    step(1, 1, 32'h300, 1, 32'h300, 7'h63, 3'd0, 1, 1, 0);
    chk("stats_br_rst", stat_branches, 32'd0);
    chk("stats_mp_rst", stat_mispredicts, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 32'h300 + 32'(k * 4), 0, 0, 0, 0, 0, 0, 0);
      chk("ctr_rst_01", {31'b0, pred_taken}, 32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ppc, rpc;
      logic [6:0]  op;
      ppc = {$urandom_range(0, 3), 22'($urandom), 6'($urandom_range(0, 15)), 2'($urandom)};
      rpc = ($urandom_range(0, 3) == 0) ? ppc
            : {$urandom_range(0, 3), 22'($urandom), 6'($urandom_range(0, 15)), 2'($urandom)};
      op  = ($urandom_range(0, 9) < 8) ? 7'h63 : 7'($urandom);
      step(($urandom_range(0, 199) == 0), 1'($urandom), ppc, 1'($urandom_range(0, 3) != 0),
           rpc, op, 3'($urandom),
           ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 3)] : $urandom,
           ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 3)] : $urandom,
           1'($urandom));
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, 32, operand and PC width.
REQ-002 Parameter BHT_ENTRIES, 64, number of 2-bit counters; power of two, 4..1024; IDX = log2(BHT_ENTRIES).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pred_valid  in  1  fetch-stage lookup request.
REQ-006 pred_pc  in  XLEN  PC of the fetched instruction.
REQ-007 pred_taken  out  1  predicted direction, registered.
REQ-008 pred_out_valid  out  1  pred_taken is meaningful this cycle.
REQ-009 res_valid  in  1  resolve request from execute stage.
REQ-010 res_pc  in  XLEN  PC of the resolving instruction.
REQ-011 res_opcode  in  7  instruction opcode.
REQ-012 res_funct3  in  3  branch condition select.
REQ-013 res_rs1, res_rs2  in  XLEN each  compare operands.
REQ-014 res_pred_taken  in  1  prediction carried down the pipe.
REQ-015 res_taken  out  1  actual direction, registered.
REQ-016 res_mispredict  out  1  res_taken != res_pred_taken, registered.
REQ-017 res_illegal  out  1  branch opcode with funct3 010/011, registered.
REQ-018 stat_branches, stat_mispredicts  out  32 each  statistics counters (see Configuration).

Function
REQ-019 Table index = pc[IDX+1:2] for both lookup and update.
REQ-020 Lookup: one-cycle latency; pred_out_valid = pred_valid delayed by one cycle; pred_taken = MSB of the indexed counter, else 0 when pred_valid was low.
REQ-021 Branch = res_valid and res_opcode 1100011.
REQ-022 Condition per funct3: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge; full XLEN comparison of rs1 vs rs2.
REQ-023 funct3 010/011 on branch: res_illegal=1, res_taken=0, res_mispredict=0, no table or statistics update.
REQ-024 Non-branch or res_valid=0: res_taken=0, res_mispredict=0, res_illegal=0, no update.
REQ-025 Legal branch: res_taken, res_mispredict and res_illegal valid one cycle after res_valid.
REQ-026 Legal branch: counter at res_pc index increments when taken and decrements when not taken, on the same edge that registers res_taken.
REQ-027 Counters saturate at 11 (taken) and 00 (not taken); no wrap.
REQ-028 Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-029 Lookup and update to the same index in the same cycle: pred_taken reflects the post-update counter (bypass).
REQ-030 Lookup and update to different indices in the same cycle proceed independently.

Reset
REQ-031 rst asserted: every counter set to 01; pred_taken, pred_out_valid, res_taken, res_mispredict, res_illegal set to 0; stat counters set to 0.
REQ-032 Requests present during the reset cycle are discarded; the first valid outputs appear one cycle after a request accepted with rst low.

Configuration
REQ-033 Macro BPU_STATS_EN defined: stat_branches increments on each legal resolved branch, and stat_mispredicts on each mispredict; both saturate at 0xFFFFFFFF and are updated on the same edge as res_*.
REQ-034 BPU_STATS_EN undefined: both stat ports remain and are tied to 0; no counter logic is generated.

Verification
REQ-035 After reset, lookup pc 0x100 -> next cycle pred_out_valid=1, pred_taken=0.
REQ-036 Resolve beq at pc 0x100, rs1=rs2=5, pred 0, three times -> res_taken=1 and res_mispredict=1 each time; counter 01->10->11->11; lookup 0x100 -> pred_taken=1.
REQ-037 blt rs1=0xFFFFFFFF, rs2=1 -> taken; bltu with the same operands -> not taken; bgeu -> taken.
REQ-038 funct3 010 with opcode 1100011 -> res_illegal=1, res_taken=0, counter unchanged, stats unchanged.
REQ-039 Same-cycle lookup and taken update at pc 0x40 from counter 01 -> pred_taken=1 (bypass); lookup 0x44 in the same cycle -> 0.
REQ-040 With BPU_STATS_EN: 10 branches, 3 mispredicts, then rst mid-stream -> 10/3 before reset, 0/0 and all counters 01 after.
